// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared op codes, state encoding and strobe bundle for the datapath sequencer
package datapath_ctrl_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_ACCUM = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_MOVE = 3'd2;
    localparam logic [2:0] ST_ADD1 = 3'd3;
    localparam logic [2:0] ST_ADD2 = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_MOVE = ST_MOVE,
        S_ADD1 = ST_ADD1,
        S_ADD2 = ST_ADD2,
        S_DONE = ST_DONE
    } state_t;

    // Bit order matches the output order RAin, RBin, RZin, RAout, RBout, RZout.
    typedef struct packed {
        logic ra_in;
        logic rb_in;
        logic rz_in;
        logic ra_out;
        logic rb_out;
        logic rz_out;
    } strobes_t;

endpackage

// File: rtl/datapath_sequencer_iter_counter.sv
// rtl/datapath_sequencer_iter_counter.sv - loadable down-counter with zero flag for ACCUM iterations
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   load_i, load_val_i   load the counter (has priority over dec_i)
//   dec_i                decrement by one; a zero count is held, never wraps
//   cnt_o, zero_o        current count and count==0 flag
module iter_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - T-state control unit driving the single-bus datapath register strobes
// Ports:
//   clock, clear          clock (rising edge), asynchronous active-low reset
//   start, op, count      request handshake: op and count are sampled with start in IDLE
//   busy, done            sequence in progress / one-cycle completion pulse
//   RAin, RBin, RZin      datapath register load enables
//   RAout, RBout, RZout   datapath bus-drive selects
//   iter                  remaining ACCUM iterations
module datapath_sequencer
    import datapath_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             RAin,
    output logic             RBin,
    output logic             RZin,
    output logic             RAout,
    output logic             RBout,
    output logic             RZout,
    output logic [CNT_W-1:0] iter
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       op_q;
    strobes_t         strobes_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic [CNT_W-1:0] iter_load_val;
    logic [CNT_W-1:0] iter_cnt;
    logic             iter_zero;

    function automatic strobes_t decode_strobes(input state_t s);
        strobes_t st;
        st = '0;
        case (s)
            S_LOAD: st.ra_in = 1'b1;
            S_MOVE: begin
                st.ra_out = 1'b1;
                st.rb_in  = 1'b1;
            end
            S_ADD1: begin
                st.rb_out = 1'b1;
                st.rz_in  = 1'b1;
            end
            S_ADD2: begin
                st.rz_out = 1'b1;
                st.rb_in  = 1'b1;
            end
            default: st = '0;
        endcase
        return st;
    endfunction

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        iter_load_val = '0;
        if (op == OP_ACCUM) begin
            iter_load_val = count;
        end else if (op == OP_ADD) begin
            iter_load_val = CNT_W'(1);
        end
    end

    iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk_i      (clock),
        .rst_ni     (clear),
        .load_i     (accept),
        .load_val_i (iter_load_val),
        .dec_i      (state_q == S_ADD2),
        .cnt_o      (iter_cnt),
        .zero_o     (iter_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_LOAD: state_d = S_LOAD;
                        OP_MOVE: state_d = S_MOVE;
                        OP_ADD:  state_d = S_ADD1;
                        default: state_d = (count == '0) ? S_DONE : S_ADD1;
                    endcase
                end
            end
            S_LOAD:  state_d = S_DONE;
            S_MOVE:  state_d = S_DONE;
            S_ADD1:  state_d = S_ADD2;
            // Loop only while more than one iteration remains before this decrement.
            S_ADD2:  state_d = ((op_q == OP_ACCUM) && !iter_zero && (iter_cnt != CNT_W'(1)))
                               ? S_ADD1 : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state register and never depend combinationally on inputs.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            strobes_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (accept) begin
                op_q <= op;
            end
            strobes_q <= decode_strobes(state_d);
            busy_q    <= (state_d == S_LOAD) || (state_d == S_MOVE) ||
                         (state_d == S_ADD1) || (state_d == S_ADD2);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign RAin  = strobes_q.ra_in;
    assign RBin  = strobes_q.rb_in;
    assign RZin  = strobes_q.rz_in;
    assign RAout = strobes_q.ra_out;
    assign RBout = strobes_q.rb_out;
    assign RZout = strobes_q.rz_out;
    assign iter  = iter_cnt;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - directed self-checking bench for datapath_sequencer with a datapath model
module tb_datapath_sequencer;
    import datapath_ctrl_pkg::*;

    localparam int CNT_W = 4;

    logic             clock;
    logic             clear;
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    logic             busy, done;
    logic             RAin, RBin, RZin, RAout, RBout, RZout;
    logic [CNT_W-1:0] iter;

    logic [31:0] imm, a_val, ra, rb, rz, bus;
    logic [5:0]  sv;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [5:0] SV_NONE = 6'b000000;
    localparam logic [5:0] SV_LOAD = 6'b100000;
    localparam logic [5:0] SV_MOVE = 6'b010100;
    localparam logic [5:0] SV_ADD1 = 6'b001010;
    localparam logic [5:0] SV_ADD2 = 6'b010001;

    datapath_sequencer #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .op    (op),
        .count (count),
        .busy  (busy),
        .done  (done),
        .RAin  (RAin),
        .RBin  (RBin),
        .RZin  (RZin),
        .RAout (RAout),
        .RBout (RBout),
        .RZout (RZout),
        .iter  (iter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign sv  = {RAin, RBin, RZin, RAout, RBout, RZout};
    assign bus = RAout ? ra : (RBout ? rb : (RZout ? rz : 32'h0));

    // Behavioural single-bus datapath driven by the strobes.
    always @(posedge clock) begin
        if (RAin) ra <= imm;
        if (RBin) rb <= bus;
        if (RZin) rz <= a_val + bus;
    end

    // Invariants sampled away from the active edge, every cycle.
    always @(negedge clock) begin
        n_chk++;
        assert ($countones({RAout, RBout, RZout}) <= 1) else begin
            n_fail++;
            $error("FAIL inv_bus_onehot: observed %b expected at most one set", {RAout, RBout, RZout});
        end
        n_chk++;
        assert (!(RBin && RBout)) else begin
            n_fail++;
            $error("FAIL inv_rb_in_out: observed RBin=%b RBout=%b expected not both", RBin, RBout);
        end
        n_chk++;
        assert (!(busy && done)) else begin
            n_fail++;
            $error("FAIL inv_busy_done: observed busy=%b done=%b expected not both", busy, done);
        end
        n_chk++;
        assert (busy || (sv === SV_NONE)) else begin
            n_fail++;
            $error("FAIL inv_idle_strobes: observed %b expected %b", sv, SV_NONE);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [31:0] v);
        imm = v; op = OP_LOAD; start = 1'b1;
        tick(); start = 1'b0;
        chk("load_k1_strobes", 32'(sv), 32'(SV_LOAD));
        chk("load_k1_busy_done", 32'({busy, done}), 32'b10);
        tick();
        chk("load_k2_busy_done", 32'({busy, done}), 32'b01);
        chk("load_k2_strobes", 32'(sv), 32'(SV_NONE));
        chk("load_ra", ra, v);
        tick();
        chk("load_idle_busy_done", 32'({busy, done}), 32'b00);
    endtask

    task automatic do_move(input logic [31:0] exp_rb);
        op = OP_MOVE; start = 1'b1;
        tick(); start = 1'b0;
        chk("move_k1_strobes", 32'(sv), 32'(SV_MOVE));
        tick();
        chk("move_k2_busy_done", 32'({busy, done}), 32'b01);
        chk("move_rb", rb, exp_rb);
        tick();
    endtask

    initial begin
        start = 1'b1; op = OP_ACCUM; count = 4'd5; imm = '0; a_val = '0;
        clear = 1'b1;
        #2 clear = 1'b0;
        tick(); tick();
        chk("rst_strobes", 32'(sv), 32'(SV_NONE));
        chk("rst_busy_done", 32'({busy, done}), 32'b00);
        chk("rst_iter", 32'(iter), 32'd0);
        clear = 1'b1; start = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_strobes", 32'(sv), 32'(SV_NONE));

        // LOAD 5 then MOVE: RB <- 5
        do_load(32'h0000_0005);
        do_move(32'h0000_0005);

        // ADD: A=3, RB=5 -> 8
        a_val = 32'h0000_0003; op = OP_ADD; start = 1'b1;
        tick(); start = 1'b0;
        chk("add_k1_strobes", 32'(sv), 32'(SV_ADD1));
        chk("add_k1_iter", 32'(iter), 32'd1);
        tick();
        chk("add_k2_strobes", 32'(sv), 32'(SV_ADD2));
        tick();
        chk("add_k3_busy_done", 32'({busy, done}), 32'b01);
        chk("add_rb", rb, 32'h0000_0008);
        chk("add_iter_end", 32'(iter), 32'd0);
        tick();

        // ACCUM 4 with A=2, RB=0 -> 8
        do_load(32'h0);
        do_move(32'h0);
        a_val = 32'h0000_0002; op = OP_ACCUM; count = 4'd4; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            chk("accum_add1_strobes", 32'(sv), 32'(SV_ADD1));
            chk("accum_add1_iter", 32'(iter), 32'(4 - i));
            chk("accum_add1_done", 32'(done), 32'd0);
            tick();
            chk("accum_add2_strobes", 32'(sv), 32'(SV_ADD2));
            chk("accum_add2_iter", 32'(iter), 32'(4 - i));
        end
        tick();
        chk("accum_k9_busy_done", 32'({busy, done}), 32'b01);
        chk("accum_k9_iter", 32'(iter), 32'd0);
        chk("accum_rb", rb, 32'h0000_0008);
        tick();
        chk("accum_idle_done", 32'(done), 32'd0);

        // ACCUM 0: straight to DONE; start during DONE is ignored
        op = OP_ACCUM; count = 4'd0; start = 1'b1;
        tick();
        chk("accum0_k1_busy_done", 32'({busy, done}), 32'b01);
        chk("accum0_k1_strobes", 32'(sv), 32'(SV_NONE));
        op = OP_LOAD;
        tick(); start = 1'b0;
        chk("done_start_ign_strobes", 32'(sv), 32'(SV_NONE));
        chk("done_start_ign_busy_done", 32'({busy, done}), 32'b00);
        tick();
        chk("done_start_ign_idle", 32'({busy, done, sv}), 32'(0));

        // ADD with start re-presented while busy: A=2, RB=8 -> 10
        op = OP_ADD; start = 1'b1;
        tick();
        chk("busy_add_k1_strobes", 32'(sv), 32'(SV_ADD1));
        op = OP_ACCUM; count = 4'd7;
        tick();
        chk("busy_add_k2_strobes", 32'(sv), 32'(SV_ADD2));
        chk("busy_add_k2_iter", 32'(iter), 32'd1);
        tick(); start = 1'b0;
        chk("busy_add_k3_busy_done", 32'({busy, done}), 32'b01);
        chk("busy_add_rb", rb, 32'h0000_000A);
        tick();
        chk("busy_add_idle", 32'({busy, done, sv}), 32'(0));

        // Reset in ACCUM iteration 2, ADD1
        op = OP_ACCUM; count = 4'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        tick();
        chk("abort_pre_strobes", 32'(sv), 32'(SV_ADD1));
        chk("abort_pre_iter", 32'(iter), 32'd2);
        #2 clear = 1'b0;
        #1;
        chk("abort_strobes_async", 32'(sv), 32'(SV_NONE));
        chk("abort_busy_done", 32'({busy, done}), 32'b00);
        chk("abort_iter", 32'(iter), 32'd0);
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        clear = 1'b1;
        tick();
        chk("abort_recover_idle", 32'({busy, done, sv}), 32'(0));
        do_load(32'h0000_0009);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control unit that drives the register-transfer strobes of the 32-bit single-bus datapath: RAin/RBin/RZin load enables and RAout/RBout/RZout bus-drive selects.
- Accepts a 2-bit operation on a start/busy/done handshake.
- Steps through a fixed T-state sequence per operation, asserting exactly the strobes the datapath needs each cycle.
- Sits between the test/top-level stimulus and the datapath; the datapath's A operand and RA immediate are supplied externally and are not seen by this block.

Parameters:
- CNT_W, 4, width of the iteration count for the ACCUM operation (max 2^CNT_W-1 iterations).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  operation: 00 LOAD (RA<-imm), 01 MOVE (RB<-RA), 10 ADD (RB<-A+RB), 11 ACCUM (ADD repeated count times).
- count  in  CNT_W  iteration count for ACCUM; sampled with start; ignored for other ops.
- busy  out  1  high while a sequence is executing.
- done  out  1  one-cycle completion pulse.
- RAin, RBin, RZin  out  1 each  datapath register load enables.
- RAout, RBout, RZout  out  1 each  datapath bus-drive selects.
- iter  out  CNT_W  remaining ACCUM iterations (debug/verification).

Behaviour:
- Reset (clear=0, async): state=IDLE; busy, done, all six strobes =0; iter=0.
  - Reset mid-sequence aborts immediately. No done is produced. Strobes drop asynchronously.
- States: IDLE, LOAD, MOVE, ADD1, ADD2, DONE. Strobes are a registered decode of the state (Moore); no strobe depends combinationally on inputs.
- IDLE: busy=0, all strobes 0.
  - On start=1, latch op and count, set busy=1 next cycle.
  - Next state: LOAD, MOVE, or ADD1. For ACCUM with count=0, go directly to DONE.
- LOAD: RAin=1 for one cycle -> DONE.
- MOVE: RAout=1, RBin=1 for one cycle -> DONE.
- ADD1: RBout=1, RZin=1; the datapath's adder computes A+RB into RZ.
- ADD2: RZout=1, RBin=1 (RB<-RZ).
  - op=ADD: -> DONE.
  - op=ACCUM: decrement iter. If iter (pre-decrement)=1 -> DONE, else -> ADD1.
- DONE: done=1, busy=0, strobes 0 -> IDLE. A start asserted in DONE is ignored (must be re-presented in IDLE).
- Latency from start cycle k:
  - LOAD/MOVE: strobes at k+1, done at k+2.
  - ADD: ADD1 at k+1, ADD2 at k+2, done at k+3.
  - ACCUM N: 2N strobe cycles, done at k+2N+1.
  - ACCUM 0: done at k+1.
- start while busy=1: ignored; latched op/count unchanged.
- Invariants, checked every cycle:
  - at most one of RAout/RBout/RZout high (bus select is one-hot or zero);
  - never RBin and RBout together;
  - busy and done never both high;
  - no strobe high in IDLE or DONE.
- iter: loaded with count on start for ACCUM, with 1 for ADD, with 0 otherwise. Decrements only in ADD2. No wrap-around: 0 is never decremented.

Decomposition:
- Shared package datapath_ctrl_pkg holds:
  - op codes OP_LOAD=2'b00, OP_MOVE=2'b01, OP_ADD=2'b10, OP_ACCUM=2'b11;
  - state encoding constants (3-bit binary).
- One natural sub-module: iter_counter, a loadable down-counter with load, dec, and zero flag, parameterised by CNT_W.
- The strobe decode stays in the top module.

Test Plan:
- Reset: hold clear=0 with start=1 and op=11 -> all outputs 0. Release -> IDLE, busy=0 on first edge.
- LOAD then MOVE with datapath attached, imm=32'h0000_0005:
  - RAin at k+1 and done at k+2;
  - MOVE gives RAout&RBin at k+1;
  - RB reads 5.
- ADD with A=32'h0000_0003, RB=5: ADD1 at k+1, ADD2 at k+2, done at k+3, RB=8. Bus select one-hot in every cycle.
- ACCUM count=4, A=2, RB=0:
  - ADD1/ADD2 alternate for 8 cycles;
  - iter steps 4,3,2,1,0;
  - done at k+9; RB=8.
- ACCUM count=0 -> no strobes, done at k+1. start pulsed during busy and during DONE -> ignored, no extra sequence.
- Reset (clear=0) asserted during ACCUM iteration 2 in ADD1:
  - strobes drop immediately, no done;
  - after release, a new LOAD completes normally.
